conv_feeder: RTL

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_pkg.sv | 26 ++
 rtl/feeder_addr_gen.sv | 67 ++++++
 rtl/conv_feeder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared state encoding and geometry helpers for the conv feeder.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_W   = 3'd1,
        ST_LOAD_I   = 3'd2,
        ST_WAIT_END = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Padded edge length of the image as seen by the computation block.
    function automatic int calc_size(input int frt, input int pad);
        return frt + pad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/feeder_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : feeder_addr_gen
// Purpose  : Row-major scan of the padded image, flags interior pixels and
//            forms their image memory address.
// Revision : 1.0 - initial release
// ============================================================================
module feeder_addr_gen
    import conv_pkg::*;
#(
    parameter int                FRT    = 14,
    parameter int                PAD    = 2,
    parameter logic [ADDR_W-1:0] I_BASE = 16'h0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_i,
    output logic              interior_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int                SIZE  = calc_size(FRT, PAD);
    localparam logic [ADDR_W-1:0] HALF  = ADDR_W'(PAD / 2);
    localparam logic [ADDR_W-1:0] LIM   = ADDR_W'(PAD / 2 + FRT);
    localparam logic [ADDR_W-1:0] MAXP  = ADDR_W'(SIZE - 1);
    localparam logic [ADDR_W-1:0] FRT16 = ADDR_W'(FRT);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] w_row_off;
    logic [ADDR_W-1:0] w_col_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // Counters wrap to (0,0) after the last position, ready for the next frame.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (step_i) begin
            if (col_q == MAXP) begin
                col_d = '0;
                row_d = (row_q == MAXP) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    assign last_o     = (row_q == MAXP) && (col_q == MAXP);
    assign interior_o = (row_q >= HALF) && (row_q < LIM) &&
                        (col_q >= HALF) && (col_q < LIM);

    assign w_row_off  = (row_q - HALF) * FRT16;
    assign w_col_off  = col_q - HALF;
    assign addr_o     = interior_o ? (I_BASE + w_row_off + w_col_off) : '0;

endmodule
`default_nettype wire

// File: rtl/conv_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_feeder
// Purpose  : Streams a weight block, then a zero-padded image, from a
//            synchronous memory into a convolution computation block.
// Revision : 1.0 - initial release
// ============================================================================
module conv_feeder
    import conv_pkg::*;
#(
    parameter int                FRT    = 14,
    parameter int                PAD    = 2,
    parameter int                W_CNT  = 9,
    parameter logic [ADDR_W-1:0] W_BASE = 16'h0000,
    parameter logic [ADDR_W-1:0] I_BASE = 16'h0100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [DATA_W-1:0] mem_rdata,
    output logic                     w_load,
    output logic signed [DATA_W-1:0] w_in,
    output logic                     i_load,
    output logic signed [DATA_W-1:0] i_in,
    input  logic                     com_end
);

    localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(W_CNT - 1);

    state_t state_q, state_d;

    logic [ADDR_W-1:0]        wcnt_q, wcnt_d;
    logic                     w_issue_w;
    logic                     w_issue_i;
    logic                     w_pix_interior;
    logic                     w_pix_last;
    logic [ADDR_W-1:0]        w_pix_addr;
    logic                     pend_w_q;
    logic                     pend_i_q;
    logic                     pend_rd_q;
    logic                     w_load_q;
    logic                     i_load_q;
    logic signed [DATA_W-1:0] w_in_q;
    logic signed [DATA_W-1:0] i_in_q;

    feeder_addr_gen #(
        .FRT    (FRT),
        .PAD    (PAD),
        .I_BASE (I_BASE)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .step_i     (w_issue_i),
        .interior_o (w_pix_interior),
        .last_o     (w_pix_last),
        .addr_o     (w_pix_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            pend_w_q  <= 1'b0;
            pend_i_q  <= 1'b0;
            pend_rd_q <= 1'b0;
            w_load_q  <= 1'b0;
            i_load_q  <= 1'b0;
            w_in_q    <= '0;
            i_in_q    <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            // Read data returns one cycle after issue; the slot tags ride along.
            pend_w_q  <= w_issue_w;
            pend_i_q  <= w_issue_i;
            pend_rd_q <= w_issue_i & w_pix_interior;
            w_load_q  <= pend_w_q;
            w_in_q    <= pend_w_q ? mem_rdata : '0;
            i_load_q  <= pend_i_q;
            i_in_q    <= (pend_i_q && pend_rd_q) ? mem_rdata : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        busy      = 1'b1;
        done      = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        w_issue_w = 1'b0;
        w_issue_i = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                mem_rd    = 1'b1;
                mem_addr  = W_BASE + wcnt_q;
                w_issue_w = 1'b1;
                if (wcnt_q == W_LAST) begin
                    wcnt_d  = '0;
                    state_d = ST_LOAD_I;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                end
            end
            ST_LOAD_I: begin
                w_issue_i = 1'b1;
                mem_rd    = w_pix_interior;
                mem_addr  = w_pix_addr;
                if (w_pix_last) begin
                    state_d = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (com_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_load = w_load_q;
    assign w_in   = w_in_q;
    assign i_load = i_load_q;
    assign i_in   = i_in_q;

endmodule
`default_nettype wire
